p_line_burst_adaptor: RTL and testbench
=======================================

// Module: p_line_burst_adaptor
// PURPOSE
// - Memory-side responder for the cache line interface (256-bit line read/write, held-request/resp handshake).
// - Serves line fills from p_i_cache and line reads/writebacks from the data cache.
// - Converts each line request into a 4-beat x 64-bit burst on the physical memory bus.
// - Sits between the cache (or its arbiter) and burst memory.
// PARAMETERS
// - s_offset   5                  line offset bits; the line is 2**s_offset bytes
// - LINE_W     256                line width in bits
// - BEAT_W     64                 burst beat width in bits
// - NUM_BEATS  LINE_W/BEAT_W (4)  beats per burst; the beat counter is $clog2(NUM_BEATS) bits
// PORTS
// - clk            in   1       clock
// - rst            in   1       synchronous, active-high reset
// - line_read      in   1       line read request, held until line_resp
// - line_write     in   1       line write request, held until line_resp
// - line_address   in   32      byte address; offset bits are ignored
// - line_wdata     in   LINE_W  write line, beat 0 = bits [63:0]
// - line_rdata     out  LINE_W  assembled read line
// - line_resp      out  1       single-cycle completion pulse
// - burst_read     out  1       burst read request
// - burst_write    out  1       burst write request
// - burst_address  out  32      {line_address[31:s_offset], s_offset'b0}, registered at accept
// - burst_wdata    out  BEAT_W  current write beat
// - burst_rdata    in   BEAT_W  read beat, valid when burst_resp=1
// - burst_resp     in   1       one beat transferred this cycle; gaps between beats allowed
// BEHAVIOUR
// - FSM states: IDLE, RD_BURST, WR_BURST, RESP, DONE.
//   - IDLE: sample requests; line_write has priority when line_read and line_write are both high.
//     On accept, latch burst_address, latch line_wdata (writes), clear the beat counter, move to RD_BURST or WR_BURST.
//   - RD_BURST: burst_read=1. Each burst_resp writes burst_rdata into line_rdata[cnt*64 +: 64] and increments cnt.
//     The beat taken with cnt==NUM_BEATS-1 moves the FSM to RESP.
//   - WR_BURST: burst_write=1; burst_wdata = latched line[cnt*64 +: 64]; cnt advances on burst_resp.
//     The final beat moves the FSM to RESP.
//   - RESP: line_resp=1 for exactly one cycle, then DONE.
//   - DONE: one dead cycle, no accept (lets the requester drop its request), then IDLE.
// - Latency: request seen in cycle 0; burst_* asserted from cycle 1; line_resp one cycle after the final beat.
//   With zero-wait memory (beats in cycles 1-4), line_resp is in cycle 5.
// - line_rdata is stable from RESP until the next read burst starts; writes never modify it.
// - burst_read/burst_write are mutually exclusive and held constant for the whole burst.
//   burst_address is constant from accept to RESP.
// - burst_resp in IDLE, RESP or DONE is ignored.
// - Requests that change mid-burst are ignored; the latched request completes.
// - Reset:
//   - All outputs are 0 (line_rdata = '0), FSM goes to IDLE, cnt = 0.
//   - Reset mid-burst aborts immediately with no line_resp; the memory model must accept the dropped request.
// - Counter wrap: cnt wraps to 0 after NUM_BEATS-1; it is never consumed in IDLE.
// CONFIGURATION
// - P_LINE_BUF_EN defined: one-entry last-line buffer (tag = address[31:s_offset], valid bit).
//   - Every completed read fill sets the tag and sets valid.
//   - A line_read in IDLE whose tag matches while valid goes straight to RESP: no burst, line_resp in cycle 1.
//   - A write to the buffered tag clears valid.
//   - rst clears valid.
// - P_LINE_BUF_EN undefined: no buffer logic; every read performs a burst.
// STRUCTURE
// - Shared package p_mem_types holds:
//   - burst_state_t enum (IDLE, RD_BURST, WR_BURST, RESP, DONE)
//   - LINE_W and BEAT_W constants
//   - function beat_sel(line, cnt)
// - One sub-module, p_line_beat_reg: 256-bit line register with per-beat write enable and beat-select read port.
//   It is instanced once for assembly and once for the write line.
// TESTING
// - Read, zero-wait memory:
//   - Stimulus: line_read, addr 0x0000_1234; beats 0x11..,0x22..,0x33..,0x44.. in cycles 1-4.
//   - Expect: burst_address 0x0000_1220; line_resp in cycle 5; line_rdata = {0x44..,0x33..,0x22..,0x11..}.
// - Write:
//   - Stimulus: line_write, addr 0x8000_0040, line_wdata = {D3,D2,D1,D0}; memory drops burst_resp for 2 cycles between beats 1 and 2.
//   - Expect: burst_wdata D0..D3 in order; burst_write held throughout; exactly one line_resp.
// - Simultaneous line_read and line_write:
//   - Expect: WR_BURST taken; burst_read never asserted.
// - Reset after beat 2 of a read:
//   - Expect: next cycle all outputs 0, no line_resp.
//   - A new read to 0x100 then completes normally with fresh data.
// - Back-to-back requests held high:
//   - Expect: exactly one line_resp per request; DONE gap of one cycle; a spurious burst_resp in DONE is ignored.
// - With P_LINE_BUF_EN:
//   - Reread of 0x1220: line_resp in cycle 1, no burst.
//   - Write to 0x1220, then read of 0x1220: a full burst.

Source files
------------

// File: rtl/p_mem_types.sv
// Package: p_mem_types
// Shared types and constants for the cache-line to memory-burst adaptor.
//   - burst_state_t : adaptor FSM states
//   - LINE_W/BEAT_W : line and burst-beat widths
//   - NUM_BEATS     : beats per line burst; CNT_W is the beat-counter width
//   - S_OFFSET      : byte-offset bits within a line
//   - beat_sel()    : extracts beat `cnt` from a line (beat 0 = bits [BEAT_W-1:0])
package p_mem_types;

    localparam int unsigned S_OFFSET  = 5;
    localparam int unsigned LINE_W    = 256;
    localparam int unsigned BEAT_W    = 64;
    localparam int unsigned NUM_BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W     = $clog2(NUM_BEATS);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        RESP,
        DONE
    } burst_state_t;

    function automatic logic [BEAT_W-1:0] beat_sel(input logic [LINE_W-1:0] line,
                                                  input logic [CNT_W-1:0]  cnt);
        return line[cnt*BEAT_W +: BEAT_W];
    endfunction

endpackage

// File: rtl/p_line_beat_reg.sv
// Module: p_line_beat_reg
// A full-line register organised as NUM_BEATS beats, each with its own write enable.
// Used both to assemble a read line beat by beat and to hold a write line while it
// is streamed out one beat at a time.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset, clears the line to zero
//   we_i      per-beat write enable
//   wdata_i   write data in line layout; beat b is taken from bits [b*BEAT_W +: BEAT_W]
//   sel_i     beat index for the beat read port
//   line_o    whole registered line
//   beat_o    registered beat sel_i
module p_line_beat_reg
    import p_mem_types::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_BEATS-1:0] we_i,
    input  logic [LINE_W-1:0]    wdata_i,
    input  logic [CNT_W-1:0]     sel_i,
    output logic [LINE_W-1:0]    line_o,
    output logic [BEAT_W-1:0]    beat_o
);

    logic [LINE_W-1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        for (int b = 0; b < NUM_BEATS; b++) begin
            if (we_i[b]) begin
                line_d[b*BEAT_W +: BEAT_W] = wdata_i[b*BEAT_W +: BEAT_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o = line_q;
    assign beat_o = beat_sel(line_q, sel_i);

endmodule

// File: rtl/p_line_burst_adaptor.sv
// Module: p_line_burst_adaptor
// Memory-side responder for the cache line interface. Each held line request is turned
// into a NUM_BEATS x BEAT_W burst on the memory bus; line_resp pulses once on completion,
// followed by one dead cycle so the requester can drop its request.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   line_read/line_write  held line requests (write wins when both are high)
//   line_address          byte address, offset bits ignored
//   line_wdata            write line, beat 0 = bits [63:0]
//   line_rdata            assembled read line, stable until the next read burst starts
//   line_resp             single-cycle completion pulse
//   burst_read/write      burst request, held for the whole burst
//   burst_address         line-aligned address latched at accept
//   burst_wdata           current write beat
//   burst_rdata           read beat, valid with burst_resp
//   burst_resp            one beat transferred this cycle
// Configuration:
//   P_LINE_BUF_EN  when defined, a one-entry last-line buffer lets a read of the most
//                  recently filled line complete without a burst (line_resp in cycle 1).
module p_line_burst_adaptor
    import p_mem_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_address,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic              burst_read,
    output logic              burst_write,
    output logic [31:0]       burst_address,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
);

    localparam int unsigned      TAG_W     = 32 - S_OFFSET;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    burst_state_t state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Line-aligned address; the offset bits are implied zero.
    logic [TAG_W-1:0]     addr_q, addr_d;

    logic [TAG_W-1:0]     req_tag;
    logic [NUM_BEATS-1:0] rd_we;
    logic [NUM_BEATS-1:0] wr_we;
    logic                 line_hit;
    logic                 fill_done;
    logic                 wr_accept;

    logic [BEAT_W-1:0]    unused_asm_beat;
    logic [LINE_W-1:0]    unused_wr_line;
    logic                 unused_offset;

    assign req_tag       = line_address[31:S_OFFSET];
    assign unused_offset = ^line_address[S_OFFSET-1:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rd_we     = '0;
        wr_we     = '0;
        fill_done = 1'b0;
        wr_accept = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (line_write) begin
                    wr_accept = 1'b1;
                    wr_we     = '1;
                    addr_d    = req_tag;
                    cnt_d     = '0;
                    state_d   = WR_BURST;
                end else if (line_read) begin
                    addr_d  = req_tag;
                    cnt_d   = '0;
                    state_d = line_hit ? RESP : RD_BURST;
                end
            end
            RD_BURST: begin
                if (burst_resp) begin
                    rd_we[cnt_q] = 1'b1;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        fill_done = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            WR_BURST: begin
                if (burst_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Last-line buffer
    // ------------------------------------------------------------------
`ifdef P_LINE_BUF_EN
    logic [TAG_W-1:0] buf_tag_q, buf_tag_d;
    logic             buf_valid_q, buf_valid_d;

    always_comb begin
        buf_tag_d   = buf_tag_q;
        buf_valid_d = buf_valid_q;
        if (fill_done) begin
            buf_tag_d   = addr_q;
            buf_valid_d = 1'b1;
        end else if (wr_accept && (buf_tag_q == req_tag)) begin
            // The buffered copy would go stale once memory takes the new line.
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_tag_q   <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            buf_tag_q   <= buf_tag_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    // line_rdata still holds the buffered line: only read bursts write the assembly reg.
    assign line_hit = buf_valid_q && (buf_tag_q == req_tag);
`else
    logic unused_buf;
    assign unused_buf = fill_done ^ wr_accept;
    assign line_hit   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Line storage: read assembly and write staging
    // ------------------------------------------------------------------
    p_line_beat_reg u_rd_line (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (rd_we),
        .wdata_i ({NUM_BEATS{burst_rdata}}),
        .sel_i   (cnt_q),
        .line_o  (line_rdata),
        .beat_o  (unused_asm_beat)
    );

    p_line_beat_reg u_wr_line (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (wr_we),
        .wdata_i (line_wdata),
        .sel_i   (cnt_q),
        .line_o  (unused_wr_line),
        .beat_o  (burst_wdata)
    );

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    assign burst_read    = (state_q == RD_BURST);
    assign burst_write   = (state_q == WR_BURST);
    assign line_resp     = (state_q == RESP);
    assign burst_address = {addr_q, {S_OFFSET{1'b0}}};

endmodule

// File: tb/tb_p_line_burst_adaptor.sv
module tb_p_line_burst_adaptor;
    import p_mem_types::*;

    localparam int MAX_CYC = 80;
`ifdef P_LINE_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              line_read = 1'b0;
    logic              line_write = 1'b0;
    logic [31:0]       line_address = '0;
    logic [LINE_W-1:0] line_wdata = '0;
    logic [LINE_W-1:0] line_rdata;
    logic              line_resp;
    logic              burst_read;
    logic              burst_write;
    logic [31:0]       burst_address;
    logic [BEAT_W-1:0] burst_wdata;
    logic [BEAT_W-1:0] burst_rdata = '0;
    logic              burst_resp = 1'b0;

    p_line_burst_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_address  (line_address),
        .line_wdata    (line_wdata),
        .line_rdata    (line_rdata),
        .line_resp     (line_resp),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Memory side (what the responder serves) and the reference view of memory.
    logic [LINE_W-1:0] mem     [logic [31:0]];
    logic [LINE_W-1:0] ref_mem [logic [31:0]];
    // Reference last-line buffer.
    logic [31:0]       buf_line = '0;
    bit                buf_valid = 1'b0;

    // Observations from one served transaction.
    logic [31:0]       obs_addr;
    logic [LINE_W-1:0] obs_rdata;
    int                obs_resp_cycle, obs_resp_count, obs_last_beat;
    bit                obs_rd_seen, obs_wr_seen, obs_held_ok;
    logic [BEAT_W-1:0] obs_wbeats [$];

    function automatic logic [LINE_W-1:0] default_line(input logic [31:0] la);
        return {la, ~la, la ^ 32'h5A5A_5A5A, la + 32'h1357_9BDF,
                la ^ 32'h0F0F_F0F0, ~la + 32'h3, la ^ 32'hDEAD_BEEF, la + 32'h1};
    endfunction

    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] la);
        if (mem.exists(la)) return mem[la];
        return default_line(la);
    endfunction

    function automatic logic [LINE_W-1:0] ref_line(input logic [31:0] la);
        if (ref_mem.exists(la)) return ref_mem[la];
        return default_line(la);
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] packed_wbeats();
        logic [LINE_W-1:0] l = '0;
        for (int i = 0; i < obs_wbeats.size() && i < NUM_BEATS; i++) l[i*BEAT_W +: BEAT_W] = obs_wbeats[i];
        return l;
    endfunction

    function automatic bit exp_hit(input logic [31:0] la);
        return BUF_EN && buf_valid && (la == buf_line);
    endfunction

    function automatic void note_fill(input logic [31:0] la);
        buf_line  = la;
        buf_valid = 1'b1;
    endfunction

    function automatic void note_write(input logic [31:0] la, input logic [LINE_W-1:0] d);
        ref_mem[la] = d;
        if (la == buf_line) buf_valid = 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [LINE_W-1:0] d);
        line_read    = rd;
        line_write   = wr;
        line_address = a;
        line_wdata   = d;
    endtask

    // Burst memory responder. Runs from cycle 1 after the request was driven in cycle 0,
    // optionally inserting a fixed gap after beat gap_after and random gaps (gap_pct %).
    // Drops the request on line_resp and stops two cycles later, or right after beat
    // stop_after has been taken.
    task automatic serve(input int gap_pct, input int gap_after, input int gap_len,
                         input int stop_after);
        int nb = 0;
        int gap_left = 0;
        bit kind_set = 1'b0;
        bit kind_wr = 1'b0;
        logic [LINE_W-1:0] rline;
        logic [LINE_W-1:0] wline = '0;
        obs_resp_cycle = -1; obs_resp_count = 0; obs_last_beat = -1;
        obs_rd_seen = 1'b0; obs_wr_seen = 1'b0; obs_held_ok = 1'b1;
        obs_wbeats.delete();
        for (int c = 1; c <= MAX_CYC; c++) begin
            step();
            burst_resp  = 1'b0;
            burst_rdata = '0;
            if (c == 1) obs_addr = burst_address;
            if (obs_resp_cycle >= 0 && c - obs_resp_cycle >= 2) break;
            if (line_resp === 1'b1) begin
                obs_resp_count++;
                if (obs_resp_cycle < 0) begin
                    obs_resp_cycle = c;
                    obs_rdata      = line_rdata;
                    line_read      = 1'b0;
                    line_write     = 1'b0;
                end
            end
            if (burst_read === 1'b1) obs_rd_seen = 1'b1;
            if (burst_write === 1'b1) obs_wr_seen = 1'b1;
            if (burst_read === 1'b1 || burst_write === 1'b1) begin
                if (burst_read === 1'b1 && burst_write === 1'b1) obs_held_ok = 1'b0;
                if (!kind_set) begin
                    kind_set = 1'b1;
                    kind_wr  = burst_write;
                end else if (burst_write !== kind_wr) begin
                    obs_held_ok = 1'b0;
                end
                if (burst_address !== obs_addr) obs_held_ok = 1'b0;
                if (gap_left > 0) begin
                    gap_left--;
                end else if ($urandom_range(99) >= gap_pct) begin
                    burst_resp = 1'b1;
                    if (burst_read === 1'b1) begin
                        rline = mem_line(burst_address);
                        burst_rdata = (nb < NUM_BEATS) ? rline[nb*BEAT_W +: BEAT_W] : '1;
                    end else begin
                        obs_wbeats.push_back(burst_wdata);
                        if (nb < NUM_BEATS) wline[nb*BEAT_W +: BEAT_W] = burst_wdata;
                        if (nb == NUM_BEATS - 1) mem[burst_address] = wline;
                    end
                    nb++;
                    obs_last_beat = c;
                    if (nb == gap_after) gap_left = gap_len;
                    if (nb == stop_after) begin
                        step();
                        burst_resp = 1'b0;
                        return;
                    end
                end
            end else if (kind_set && obs_resp_cycle < 0 && line_resp !== 1'b1) begin
                obs_held_ok = 1'b0;
            end
        end
        burst_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; line_read = 1'b0; line_write = 1'b0; burst_resp = 1'b0;
        repeat (3) step();
        vectors++; if (line_resp !== 1'b0) begin miscompares++; $display("FAIL reset line_resp got %b want 0", line_resp); end
        vectors++; if (burst_read !== 1'b0) begin miscompares++; $display("FAIL reset burst_read got %b want 0", burst_read); end
        vectors++; if (burst_write !== 1'b0) begin miscompares++; $display("FAIL reset burst_write got %b want 0", burst_write); end
        vectors++; if (burst_address !== 32'h0) begin miscompares++; $display("FAIL reset burst_address got %h want 0", burst_address); end
        vectors++; if (burst_wdata !== '0) begin miscompares++; $display("FAIL reset burst_wdata got %h want 0", burst_wdata); end
        vectors++; if (line_rdata !== '0) begin miscompares++; $display("FAIL reset line_rdata got %h want 0", line_rdata); end
        rst = 1'b0;
        buf_valid = 1'b0;
        step();
    endtask

    task automatic test_read_zero_wait();
        logic [LINE_W-1:0] exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        mem[32'h1220] = exp;
        ref_mem[32'h1220] = exp;
        start_req(1'b1, 1'b0, 32'h0000_1234, '0);
        serve(0, -1, 0, -1);
        vectors++; if (obs_addr !== 32'h0000_1220) begin miscompares++; $display("FAIL rd0 burst_address got %h want 00001220", obs_addr); end
        vectors++; if (obs_resp_cycle != 5) begin miscompares++; $display("FAIL rd0 resp_cycle got %0d want 5", obs_resp_cycle); end
        vectors++; if (obs_resp_count != 1) begin miscompares++; $display("FAIL rd0 resp_count got %0d want 1", obs_resp_count); end
        vectors++; if (obs_rdata !== exp) begin miscompares++; $display("FAIL rd0 line_rdata got %h want %h", obs_rdata, exp); end
        vectors++; if (obs_wr_seen || !obs_rd_seen) begin miscompares++; $display("FAIL rd0 burst kind got rd=%b wr=%b want rd=1 wr=0", obs_rd_seen, obs_wr_seen); end
        vectors++; if (!obs_held_ok) begin miscompares++; $display("FAIL rd0 burst held got unstable want stable"); end
        note_fill(32'h1220);
    endtask

    task automatic test_line_buf();
        logic [LINE_W-1:0] nd = rand_line();
        bit hit = exp_hit(32'h1220);
        start_req(1'b1, 1'b0, 32'h0000_1220, '0);
        serve(0, -1, 0, -1);
        vectors++; if (obs_resp_cycle != (hit ? 1 : 5)) begin miscompares++; $display("FAIL reread resp_cycle got %0d want %0d", obs_resp_cycle, hit ? 1 : 5); end
        vectors++; if (obs_rd_seen !== !hit) begin miscompares++; $display("FAIL reread burst_read_seen got %b want %b", obs_rd_seen, !hit); end
        vectors++; if (obs_rdata !== ref_line(32'h1220)) begin miscompares++; $display("FAIL reread line_rdata got %h want %h", obs_rdata, ref_line(32'h1220)); end
        note_fill(32'h1220);
        start_req(1'b0, 1'b1, 32'h0000_1220, nd);
        serve(0, -1, 0, -1);
        vectors++; if (obs_resp_count != 1) begin miscompares++; $display("FAIL bufwr resp_count got %0d want 1", obs_resp_count); end
        note_write(32'h1220, nd);
        start_req(1'b1, 1'b0, 32'h0000_1220, '0);
        serve(0, -1, 0, -1);
        vectors++; if (!obs_rd_seen || obs_resp_cycle != 5) begin miscompares++; $display("FAIL rd_after_wr burst got rd=%b cycle=%0d want rd=1 cycle=5", obs_rd_seen, obs_resp_cycle); end
        vectors++; if (obs_rdata !== nd) begin miscompares++; $display("FAIL rd_after_wr line_rdata got %h want %h", obs_rdata, nd); end
        note_fill(32'h1220);
    endtask

    task automatic test_write_gaps();
        logic [LINE_W-1:0] d = rand_line();
        start_req(1'b0, 1'b1, 32'h8000_0040, d);
        serve(0, 2, 2, -1);
        vectors++; if (obs_wbeats.size() != NUM_BEATS) begin miscompares++; $display("FAIL wr beats got %0d want 4", obs_wbeats.size()); end
        for (int i = 0; i < NUM_BEATS; i++) begin
            vectors++;
            if (i >= obs_wbeats.size() || obs_wbeats[i] !== d[i*BEAT_W +: BEAT_W]) begin
                miscompares++;
                $display("FAIL wr beat%0d got %h want %h", i, (i < obs_wbeats.size()) ? obs_wbeats[i] : '0, d[i*BEAT_W +: BEAT_W]);
            end
        end
        vectors++; if (obs_resp_cycle != 7) begin miscompares++; $display("FAIL wr resp_cycle got %0d want 7", obs_resp_cycle); end
        vectors++; if (obs_resp_count != 1) begin miscompares++; $display("FAIL wr resp_count got %0d want 1", obs_resp_count); end
        vectors++; if (!obs_held_ok || obs_rd_seen) begin miscompares++; $display("FAIL wr burst_write held got ok=%b rd=%b want ok=1 rd=0", obs_held_ok, obs_rd_seen); end
        vectors++; if (obs_addr !== 32'h8000_0040) begin miscompares++; $display("FAIL wr burst_address got %h want 80000040", obs_addr); end
        note_write(32'h8000_0040, d);
    endtask

    task automatic test_simultaneous();
        logic [LINE_W-1:0] d = rand_line();
        start_req(1'b1, 1'b1, 32'h0000_3047, d);
        serve(0, -1, 0, -1);
        vectors++; if (!obs_wr_seen || obs_rd_seen) begin miscompares++; $display("FAIL both kind got rd=%b wr=%b want rd=0 wr=1", obs_rd_seen, obs_wr_seen); end
        vectors++; if (packed_wbeats() !== d) begin miscompares++; $display("FAIL both wdata got %h want %h", packed_wbeats(), d); end
        vectors++; if (obs_resp_count != 1) begin miscompares++; $display("FAIL both resp_count got %0d want 1", obs_resp_count); end
        note_write(32'h0000_3040, d);
    endtask

    task automatic test_reset_mid_burst();
        logic [LINE_W-1:0] fresh = rand_line();
        start_req(1'b1, 1'b0, 32'h0000_2040, '0);
        serve(0, -1, 0, 2);
        rst = 1'b1; line_read = 1'b0;
        step();
        buf_valid = 1'b0;
        vectors++; if (line_resp !== 1'b0) begin miscompares++; $display("FAIL rstmid line_resp got %b want 0", line_resp); end
        vectors++; if (burst_read !== 1'b0 || burst_write !== 1'b0) begin miscompares++; $display("FAIL rstmid burst got rd=%b wr=%b want 0", burst_read, burst_write); end
        vectors++; if (burst_address !== 32'h0 || burst_wdata !== '0) begin miscompares++; $display("FAIL rstmid addr/wdata got %h/%h want 0", burst_address, burst_wdata); end
        vectors++; if (line_rdata !== '0) begin miscompares++; $display("FAIL rstmid line_rdata got %h want 0", line_rdata); end
        rst = 1'b0;
        step();
        vectors++; if (line_resp !== 1'b0 || burst_read !== 1'b0) begin miscompares++; $display("FAIL rstmid after got resp=%b rd=%b want 0", line_resp, burst_read); end
        mem[32'h100] = fresh;
        ref_mem[32'h100] = fresh;
        start_req(1'b1, 1'b0, 32'h0000_0100, '0);
        serve(0, -1, 0, -1);
        vectors++; if (obs_rdata !== fresh) begin miscompares++; $display("FAIL rstmid fresh rdata got %h want %h", obs_rdata, fresh); end
        vectors++; if (obs_resp_cycle != 5 || obs_resp_count != 1) begin miscompares++; $display("FAIL rstmid fresh resp got cycle=%0d count=%0d want 5/1", obs_resp_cycle, obs_resp_count); end
        note_fill(32'h100);
    endtask

    task automatic test_back_to_back();
        logic [LINE_W-1:0] d = rand_line();
        int resp_cycles[$];
        int wbeats = 0;
        int bad = 0;
        bit prev_resp = 1'b0;
        start_req(1'b0, 1'b1, 32'h0000_5000, d);
        for (int c = 1; c <= 21; c++) begin
            step();
            burst_resp = 1'b0;
            if (line_resp === 1'b1) resp_cycles.push_back(c);
            if (burst_write === 1'b1) begin
                if (burst_wdata !== d[(wbeats % NUM_BEATS)*BEAT_W +: BEAT_W]) bad++;
                burst_resp = 1'b1;
                wbeats++;
            end else if (prev_resp) begin
                burst_resp  = 1'b1;   // spurious beat while the adaptor is in its dead cycle
                burst_rdata = {$urandom, $urandom};
            end
            prev_resp = (line_resp === 1'b1);
            if (c == 19) line_write = 1'b0;
        end
        burst_resp = 1'b0;
        vectors++; if (resp_cycles.size() != 3) begin miscompares++; $display("FAIL b2b resp_count got %0d want 3", resp_cycles.size()); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= resp_cycles.size() || resp_cycles[i] != 5 + 7 * i) begin
                miscompares++;
                $display("FAIL b2b resp%0d cycle got %0d want %0d", i, (i < resp_cycles.size()) ? resp_cycles[i] : -1, 5 + 7 * i);
            end
        end
        vectors++; if (wbeats != 12 || bad != 0) begin miscompares++; $display("FAIL b2b beats got %0d (bad %0d) want 12 (bad 0)", wbeats, bad); end
        mem[32'h5000] = d;
        note_write(32'h5000, d);
    endtask

    task automatic test_random();
        logic [31:0] pool [4];
        logic [31:0] a, la;
        logic [LINE_W-1:0] wd, exp;
        int op, gp;
        bit hit;
        pool[0] = 32'h0000_1220; pool[1] = 32'h8000_0040; pool[2] = 32'h0000_0100; pool[3] = 32'h0000_ABC0;
        for (int t = 0; t < 30; t++) begin
            op  = $urandom_range(2);
            a   = pool[$urandom_range(3)] | 32'($urandom_range(31));
            la  = a & 32'hFFFF_FFE0;
            wd  = rand_line();
            gp  = ($urandom_range(1) == 1) ? 40 : 0;
            hit = (op == 0) && exp_hit(la);
            start_req(op != 1, op != 0, a, wd);
            serve(gp, -1, 0, -1);
            vectors++; if (obs_resp_count != 1 || !obs_held_ok) begin miscompares++; $display("FAIL rnd%0d resp got count=%0d held=%b want 1/1", t, obs_resp_count, obs_held_ok); end
            vectors++; if (obs_addr !== la) begin miscompares++; $display("FAIL rnd%0d burst_address got %h want %h", t, obs_addr, la); end
            if (op != 0) begin
                vectors++; if (!obs_wr_seen || obs_rd_seen || obs_wbeats.size() != NUM_BEATS) begin miscompares++; $display("FAIL rnd%0d wr kind got wr=%b rd=%b beats=%0d want 1/0/4", t, obs_wr_seen, obs_rd_seen, obs_wbeats.size()); end
                vectors++; if (packed_wbeats() !== wd) begin miscompares++; $display("FAIL rnd%0d wdata got %h want %h", t, packed_wbeats(), wd); end
                vectors++; if (obs_resp_cycle != obs_last_beat + 1) begin miscompares++; $display("FAIL rnd%0d wr resp_cycle got %0d want %0d", t, obs_resp_cycle, obs_last_beat + 1); end
                note_write(la, wd);
            end else begin
                exp = ref_line(la);
                vectors++; if (obs_rd_seen !== !hit || obs_wr_seen) begin miscompares++; $display("FAIL rnd%0d rd kind got rd=%b wr=%b want rd=%b wr=0", t, obs_rd_seen, obs_wr_seen, !hit); end
                vectors++; if (obs_rdata !== exp) begin miscompares++; $display("FAIL rnd%0d line_rdata got %h want %h", t, obs_rdata, exp); end
                vectors++; if (obs_resp_cycle != (hit ? 1 : obs_last_beat + 1)) begin miscompares++; $display("FAIL rnd%0d rd resp_cycle got %0d want %0d", t, obs_resp_cycle, hit ? 1 : obs_last_beat + 1); end
                if (!hit) note_fill(la);
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_zero_wait();
        test_line_buf();
        test_write_gaps();
        test_simultaneous();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
